// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
// Forward-select encodings, scoreboard entry layout and the forward priority helper.
package pipe_pkg;

    localparam int MAX_AW = 8;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic              is_load;
        logic [MAX_AW-1:0] rd;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    // The producer one stage ahead holds the youngest value, so EX/MEM wins.
    function automatic logic [1:0] fwd_sel(input logic match_ex, input logic match_mem);
        if (match_ex)
            return FWD_EXMEM;
        else if (match_mem)
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - ID-stage request and hazard-control response bundle
// master drives the decoded instruction and branch outcome; slave is the controller.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    logic              id_wr_en;
    logic              id_is_load;
    logic [REG_AW-1:0] id_wr_reg;
    logic              br_taken;
    logic              stall_if;
    logic              bubble_ex;
    logic              flush_ifid;
    logic [2:0]        flush_mask;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [2:0]        stage_valid;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_wr_en, id_is_load, id_wr_reg, br_taken,
        input  stall_if, bubble_ex, flush_ifid, flush_mask,
               fwd_a, fwd_b, stage_valid, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_wr_en, id_is_load, id_wr_reg, br_taken,
        output stall_if, bubble_ex, flush_ifid, flush_mask,
               fwd_a, fwd_b, stage_valid, stall_cnt
    );
endinterface

// File: rtl/hazard_cmp.sv
// rtl/hazard_cmp.sv - one ID source operand compared against one scoreboard entry
// Register 0 is hard-wired, so it never produces a match.
module hazard_cmp
    import pipe_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic              used,
    input  logic [AW-1:0]     src,
    input  logic              e_valid,
    input  logic              e_wr_en,
    input  logic [MAX_AW-1:0] e_rd,
    output logic              match
);
    assign match = used && e_valid && e_wr_en && (src != '0) && (e_rd == MAX_AW'(src));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use/RAW stall, branch flush and forwarding control
// HAZARD_FWD_EN enables EX operand forwarding; undefined, every RAW on EX/MEM stalls.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int BR_STAGE = 2,
    parameter int CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    pipe_hazard_ctrl_if.slave bus
);
    generate
        if (BR_STAGE != 1 && BR_STAGE != 2) begin : g_bad_br_stage
            $error("pipe_hazard_ctrl: BR_STAGE must be 1 or 2");
        end
        if (REG_AW < 1 || REG_AW > MAX_AW) begin : g_bad_reg_aw
            $error("pipe_hazard_ctrl: REG_AW out of range");
        end
    endgenerate

    localparam logic [2:0] FLUSH_BITS = (BR_STAGE == 2) ? 3'b001 : 3'b000;
    localparam bit         KILL_EX    = (BR_STAGE == 2);

    // Index 0 = EX occupant, 1 = MEM, 2 = WB.
    sb_entry_t        sb [0:2];
    logic [CNT_W-1:0] cnt;
    logic             match_rs_ex, match_rt_ex, match_rs_mem, match_rt_mem;
    logic             hazard, stall, load_en, kill_ex;
    sb_entry_t        id_entry;

    hazard_cmp #(.AW(REG_AW)) u_rs_ex (
        .used(bus.id_rs_used), .src(bus.id_rs),
        .e_valid(sb[0].valid), .e_wr_en(sb[0].wr_en), .e_rd(sb[0].rd), .match(match_rs_ex));
    hazard_cmp #(.AW(REG_AW)) u_rt_ex (
        .used(bus.id_rt_used), .src(bus.id_rt),
        .e_valid(sb[0].valid), .e_wr_en(sb[0].wr_en), .e_rd(sb[0].rd), .match(match_rt_ex));
    hazard_cmp #(.AW(REG_AW)) u_rs_mem (
        .used(bus.id_rs_used), .src(bus.id_rs),
        .e_valid(sb[1].valid), .e_wr_en(sb[1].wr_en), .e_rd(sb[1].rd), .match(match_rs_mem));
    hazard_cmp #(.AW(REG_AW)) u_rt_mem (
        .used(bus.id_rt_used), .src(bus.id_rt),
        .e_valid(sb[1].valid), .e_wr_en(sb[1].wr_en), .e_rd(sb[1].rd), .match(match_rt_mem));

`ifdef HAZARD_FWD_EN
    assign hazard = bus.id_valid && sb[0].is_load && (match_rs_ex || match_rt_ex);
`else
    // WB is covered by the register file writing in the first half-cycle.
    assign hazard = bus.id_valid && (match_rs_ex || match_rt_ex || match_rs_mem || match_rt_mem);
`endif

    // A taken branch squashes the ID instruction, so its hazard is moot.
    assign stall    = hazard && !bus.br_taken;
    assign load_en  = bus.id_valid && !stall && !bus.br_taken;
    assign kill_ex  = bus.br_taken && KILL_EX;
    assign id_entry = '{valid: 1'b1, wr_en: bus.id_wr_en, is_load: bus.id_is_load,
                        rd: MAX_AW'(bus.id_wr_reg)};

    assign bus.stall_if    = stall;
    assign bus.bubble_ex   = stall;
    assign bus.flush_ifid  = bus.br_taken;
    assign bus.flush_mask  = bus.br_taken ? FLUSH_BITS : 3'b000;
    assign bus.stage_valid = {sb[2].valid, sb[1].valid, sb[0].valid};
    assign bus.stall_cnt   = cnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sb[0] <= SB_BUBBLE;
            sb[1] <= SB_BUBBLE;
            sb[2] <= SB_BUBBLE;
            cnt   <= '0;
        end else begin
            sb[0]       <= load_en ? id_entry : SB_BUBBLE;
            sb[1]       <= sb[0];
            sb[1].valid <= sb[0].valid && !kill_ex;
            sb[2]       <= sb[1];
            if (stall && cnt != '1)
                cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef HAZARD_FWD_EN
    logic [1:0] fwd_a_q, fwd_b_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= load_en ? fwd_sel(match_rs_ex, match_rs_mem) : FWD_RF;
            fwd_b_q <= load_en ? fwd_sel(match_rt_ex, match_rt_mem) : FWD_RF;
        end
    end

    assign bus.fwd_a = fwd_a_q;
    assign bus.fwd_b = fwd_b_q;
`else
    assign bus.fwd_a = FWD_RF;
    assign bus.fwd_b = FWD_RF;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed scoreboard bench for pipe_hazard_ctrl
// Expectations follow HAZARD_FWD_EN when the bench is built with it.
module tb_pipe_hazard_ctrl;
    localparam int AW = 5;
    localparam int CW = 2;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 Clk = ~Clk;

    pipe_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(.REG_AW(AW), .BR_STAGE(2), .CNT_W(CW)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    typedef struct {
        logic       st;
        logic       fl;
        logic [2:0] mk;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [2:0] sv;
        logic [1:0] cnt;
        bit         full;
    } exp_t;

    exp_t exp_q [$];

`ifdef HAZARD_FWD_EN
    bit         st_tab  [0:8] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
    logic [1:0] cnt_tab [0:8] = '{0, 0, 1, 1, 2, 2, 3, 3, 3};
`else
    bit         st_tab  [0:8] = '{0, 1, 1, 0, 1, 1, 0, 1, 1};
    logic [1:0] cnt_tab [0:8] = '{0, 0, 1, 2, 2, 3, 3, 3, 3};
`endif

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic rsu, input logic rtu, input logic wr, input logic ld,
                         input logic [AW-1:0] wreg, input logic br);
        bus.id_valid   = v;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_rs_used = rsu;
        bus.id_rt_used = rtu;
        bus.id_wr_en   = wr;
        bus.id_is_load = ld;
        bus.id_wr_reg  = wreg;
        bus.br_taken   = br;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_full(input logic st, input logic fl, input logic [2:0] mk,
                               input logic [1:0] fa, input logic [1:0] fb,
                               input logic [2:0] sv, input logic [1:0] cnt);
        exp_t e;
        e = '{st: st, fl: fl, mk: mk, fa: fa, fb: fb, sv: sv, cnt: cnt, full: 1'b1};
        exp_q.push_back(e);
    endtask

    task automatic expect_st(input logic st, input logic [1:0] cnt);
        exp_t e;
        e = '{st: st, fl: 1'b0, mk: 3'b000, fa: 2'b00, fb: 2'b00, sv: 3'b000, cnt: cnt, full: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, "stall_if",  32'(bus.stall_if),  32'(e.st));
            chk(tag, "bubble_ex", 32'(bus.bubble_ex), 32'(e.st));
            chk(tag, "stall_cnt", 32'(bus.stall_cnt), 32'(e.cnt));
            if (e.full) begin
                chk(tag, "flush_ifid",  32'(bus.flush_ifid),  32'(e.fl));
                chk(tag, "flush_mask",  32'(bus.flush_mask),  32'(e.mk));
                chk(tag, "fwd_a",       32'(bus.fwd_a),       32'(e.fa));
                chk(tag, "fwd_b",       32'(bus.fwd_b),       32'(e.fb));
                chk(tag, "stage_valid", 32'(bus.stage_valid), 32'(e.sv));
            end
        end
    endtask

    task automatic sample(input string tag);
        @(negedge Clk);
        check_pop(tag);
    endtask

    task automatic advance();
        @(posedge Clk);
        #1;
    endtask

    task automatic cycle(input string tag);
        sample(tag);
        advance();
    endtask

    task automatic do_reset(input string tag);
        Rst = 1'b0;
        idle();
        advance();
        expect_full(0, 0, 3'b000, 2'b00, 2'b00, 3'b000, 2'd0);
        cycle({tag, "_rst"});
        Rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();

        // load then dependent add
        do_reset("A");
        drive(1, 1, 0, 1, 0, 1, 1, 2, 0);
        expect_full(0, 0, 3'b000, 2'b00, 2'b00, 3'b000, 2'd0); cycle("A0");
        drive(1, 2, 4, 1, 1, 1, 0, 3, 0);
        expect_full(1, 0, 3'b000, 2'b00, 2'b00, 3'b001, 2'd0); cycle("A1");
`ifdef HAZARD_FWD_EN
        expect_full(0, 0, 3'b000, 2'b00, 2'b00, 3'b010, 2'd1); cycle("A2");
        idle();
        expect_full(0, 0, 3'b000, 2'b10, 2'b00, 3'b101, 2'd1); cycle("A3");
`else
        expect_full(1, 0, 3'b000, 2'b00, 2'b00, 3'b010, 2'd1); cycle("A2");
        expect_full(0, 0, 3'b000, 2'b00, 2'b00, 3'b100, 2'd2); cycle("A3");
        idle();
        expect_full(0, 0, 3'b000, 2'b00, 2'b00, 3'b001, 2'd2); cycle("A4");
`endif

        // ALU result consumed by both operands of the next instruction
        do_reset("B");
        drive(1, 1, 1, 1, 1, 1, 0, 5, 0);
        expect_full(0, 0, 3'b000, 2'b00, 2'b00, 3'b000, 2'd0); cycle("B0");
        drive(1, 5, 5, 1, 1, 1, 0, 6, 0);
`ifdef HAZARD_FWD_EN
        expect_full(0, 0, 3'b000, 2'b00, 2'b00, 3'b001, 2'd0); cycle("B1");
        idle();
        expect_full(0, 0, 3'b000, 2'b01, 2'b01, 3'b011, 2'd0); cycle("B2");
`else
        expect_full(1, 0, 3'b000, 2'b00, 2'b00, 3'b001, 2'd0); cycle("B1");
        expect_full(1, 0, 3'b000, 2'b00, 2'b00, 3'b010, 2'd1); cycle("B2");
        expect_full(0, 0, 3'b000, 2'b00, 2'b00, 3'b100, 2'd2); cycle("B3");
        idle();
        expect_full(0, 0, 3'b000, 2'b00, 2'b00, 3'b001, 2'd2); cycle("B4");
`endif

        // register 0 never creates a dependency
        do_reset("C");
        drive(1, 1, 1, 1, 1, 1, 0, 0, 0);
        expect_full(0, 0, 3'b000, 2'b00, 2'b00, 3'b000, 2'd0); cycle("C0");
        drive(1, 0, 0, 1, 1, 1, 0, 7, 0);
        expect_full(0, 0, 3'b000, 2'b00, 2'b00, 3'b001, 2'd0); cycle("C1");
        idle();
        expect_full(0, 0, 3'b000, 2'b00, 2'b00, 3'b011, 2'd0); cycle("C2");

        // taken branch in MEM while a load-use is pending
        do_reset("D");
        drive(1, 1, 0, 1, 0, 1, 1, 2, 0);
        expect_full(0, 0, 3'b000, 2'b00, 2'b00, 3'b000, 2'd0); cycle("D0");
        drive(1, 2, 0, 1, 0, 1, 0, 3, 1);
        expect_full(0, 1, 3'b001, 2'b00, 2'b00, 3'b001, 2'd0); cycle("D1");
        drive(1, 2, 0, 1, 0, 1, 0, 3, 0);
        expect_full(0, 0, 3'b000, 2'b00, 2'b00, 3'b000, 2'd0); cycle("D2");
        idle();
        expect_full(0, 0, 3'b000, 2'b00, 2'b00, 3'b001, 2'd0); cycle("D3");

        // self-dependent load chain saturates the counter, reset lands mid-stall
        do_reset("E");
        drive(1, 2, 0, 1, 0, 1, 1, 2, 0);
        for (int i = 0; i < 7; i++) begin
            expect_st(st_tab[i], cnt_tab[i]);
            cycle($sformatf("E%0d", i));
        end
        expect_st(st_tab[7], cnt_tab[7]);
        sample("E7");
        #1 Rst = 1'b0;
        #1;
        expect_full(0, 0, 3'b000, 2'b00, 2'b00, 3'b000, 2'd0);
        check_pop("E_async_rst");
        advance();
        Rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            expect_st(st_tab[i], cnt_tab[i]);
            cycle($sformatf("F%0d", i));
        end

        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5: register-address width.
REQ-002 Parameter BR_STAGE, default 2: stage resolving branches (1=EX, 2=MEM); other values are illegal and SHALL fail elaboration.
REQ-003 Parameter CNT_W, default 16: stall-counter width.
REQ-004 Port Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 Port Rst  input  1  asynchronous, active-low reset.
REQ-006 Port id_valid  input  1  ID holds a valid instruction.
REQ-007 Ports id_rs, id_rt  input  REG_AW  source registers of the ID instruction.
REQ-008 Ports id_rs_used, id_rt_used  input  1  the source is actually read.
REQ-009 Ports id_wr_en, id_is_load  input  1  the ID instruction writes a register / is a load.
REQ-010 Port id_wr_reg  input  REG_AW  destination register of the ID instruction.
REQ-011 Port br_taken  input  1  branch taken in stage BR_STAGE this cycle.
REQ-012 Port stall_if  output  1  hold PC and IF/ID.
REQ-013 Port bubble_ex  output  1  load a bubble into ID/EX.
REQ-014 Port flush_ifid  output  1  invalidate IF/ID.
REQ-015 Port flush_mask  output  3  bit k-1 set: invalidate pipeline register feeding stage k (1=EX, 2=MEM, 3=WB).
REQ-016 Ports fwd_a, fwd_b  output  2  EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 reserved.
REQ-017 Port stage_valid  output  3  valid bits of EX, MEM, WB occupants.
REQ-018 Port stall_cnt  output  CNT_W  saturating count of stall cycles.

Function
REQ-019 Scoreboard SHALL hold three entries (EX, MEM, WB), each {valid, wr_en, is_load, reg}, and shift one stage per cycle.
REQ-020 EX entry SHALL load the ID instruction when id_valid && !stall_if && !br_taken, else a bubble (valid=0).
REQ-021 Register 0 SHALL never cause a hazard or a forward.
REQ-022 A source "matches" an entry when used, entry valid, wr_en=1, reg equal, reg!=0.
REQ-023 With forwarding, stall_if=bubble_ex=1 when the EX entry is a load matching either ID source; one stall cycle per load-use pair.
REQ-024 fwd_a/fwd_b SHALL be registered: computed at ID and valid while that instruction is in EX; 01 when the EX entry matches, else 10 when the MEM entry matches, else 00; EX/MEM takes priority.
REQ-025 fwd_* SHALL be 00 in cycles where EX holds a bubble.
REQ-026 br_taken SHALL assert flush_ifid and flush_mask bits for stages younger than BR_STAGE (BR_STAGE=1: 000; 2: 001) and invalidate those scoreboard entries in the same edge.
REQ-027 br_taken and a hazard in the same cycle: branch wins; stall_if=0, bubble_ex=0, counter unchanged.
REQ-028 stall_cnt SHALL increment on every stall_if cycle and saturate at all-ones.
REQ-029 stall_if, bubble_ex, flush_ifid, flush_mask SHALL be combinational from scoreboard and ID inputs (zero-cycle latency).

Reset
REQ-030 Rst low SHALL asynchronously clear all scoreboard entries, stage_valid=000, fwd_a=fwd_b=00, stall_cnt=0; derived outputs are then 0.
REQ-031 Reset mid-stall or mid-flush SHALL abandon it; the first cycle after release SHALL show no hazard.

Configuration
REQ-032 Macro HAZARD_FWD_EN defined: REQ-023..REQ-025 apply.
REQ-033 Macro undefined: fwd_a=fwd_b=00 always; stall_if=bubble_ex=1 whenever an ID source matches the EX or MEM entry (regfile write-before-read covers WB).

Structure
REQ-034 Package pipe_pkg SHALL hold the fwd select constants and the scoreboard entry typedef.
REQ-035 One sub-module hazard_cmp (source-vs-entry match) SHALL be instantiated per source per entry.

Verification
REQ-036 lw $2 then add $3,$2,$4 -> one cycle stall_if=bubble_ex=1, stall_cnt=1, then fwd_a=10 for add in EX (FWD_EN).
REQ-037 add $5,$1,$1 then sub $6,$5,$5 -> no stall; fwd_a=fwd_b=01 for sub in EX.
REQ-038 add $0,$1,$1 then add $7,$0,$0 -> no stall, fwd=00.
REQ-039 BR_STAGE=2, br_taken with load-use pending -> flush_ifid=1, flush_mask=001, stall_if=0, counter unchanged.
REQ-040 Without HAZARD_FWD_EN, add $5 then sub using $5 -> two stall cycles, stall_cnt=2.
REQ-041 Rst low during a stall, CNT_W=2 saturation preloaded -> all outputs 0 immediately; counter restarts from 0 and stops at 3.
